// File: rtl/lab_11_gen_if.sv
// lab_11_gen_if: valid/ready sample stream from the waveform source to its sink.
//   data  : sample, WIDTH bits (source -> sink)
//   valid : sample valid (source -> sink)
//   ready : sink ready (sink -> source)
// Modports: master (source side), slave (sink side).
interface lab_11_gen_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/lab_11_gen.sv
// lab_11_gen: streaming test-waveform source (saw, triangle, square, constant).
// On start_i the configuration is latched and a counted (count_i != 0) or unbounded
// (count_i == 0) sequence is emitted, one sample per accepted valid/ready beat.
// Ports:
//   clk_i, srst_i      : clock, synchronous active-high reset
//   start_i, stop_i    : start (honoured in idle), abort (honoured while running)
//   mode_i, amp_i, step_i, period_i, count_i : waveform configuration, latched at start
//   src (master)       : sample stream out (data/valid) with sink ready in
//   busy_o             : high while a sequence is running or draining
//   done_o             : one-cycle pulse on the cycle after the last beat
// Optional feature: define LAB_11_GEN_NOISE_EN to add saturated LFSR noise of
// NOISE_BITS bits to every sample.
module lab_11_gen #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned PERIOD_W   = 8,
  parameter int unsigned NOISE_BITS = 3
) (
  input  logic                clk_i,
  input  logic                srst_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic [1:0]          mode_i,
  input  logic [WIDTH-1:0]    amp_i,
  input  logic [WIDTH-1:0]    step_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [15:0]         count_i,
  lab_11_gen_if.master        src,
  output logic                busy_o,
  output logic                done_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;
  typedef enum logic [1:0] {ModeSaw, ModeTri, ModeSquare, ModeConst} mode_e;

  // Out-of-range noise widths leave no hardware behind; the block only names the case.
  if (NOISE_BITS == 0 || NOISE_BITS > WIDTH) begin : g_noise_bits_out_of_range
  end

  state_e                state_q, state_d;
  mode_e                 mode_q, mode_d;
  logic [WIDTH-1:0]      amp_q, amp_d, step_q, step_d;
  logic [PERIOD_W-1:0]   period_q, period_d;
  logic [15:0]           count_q, count_d, cnt_q, cnt_d;
  logic [WIDTH-1:0]      v_q, v_d;
  logic                  up_q, up_d, lvl_q, lvl_d;
  logic [PERIOD_W-1:0]   h_q, h_d;
  logic [WIDTH-1:0]      data_q, data_d;
  logic                  valid_q, valid_d, done_q, done_d;

  logic                  hs, last_beat, load;
  logic [WIDTH:0]        sum;
  logic [PERIOD_W-1:0]   period_last;
  logic [WIDTH-1:0]      v_adv, shape;
  logic                  up_adv, lvl_adv;
  logic [PERIOD_W-1:0]   h_adv;

  assign hs        = valid_q & src.ready;
  assign last_beat = (count_q != 16'd0) && (cnt_q + 16'd1 == count_q);
  // One extra bit so v+step never wraps before the ceiling compare.
  assign sum       = {1'b0, v_q} + {1'b0, step_q};
  assign period_last = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);

  // Waveform state after one accepted beat.
  always_comb begin
    v_adv   = v_q;
    up_adv  = up_q;
    h_adv   = h_q;
    lvl_adv = lvl_q;
    case (mode_q)
      ModeSaw: v_adv = (sum > {1'b0, amp_q}) ? '0 : sum[WIDTH-1:0];
      ModeTri: begin
        if (up_q) begin
          if (sum >= {1'b0, amp_q}) begin
            v_adv  = amp_q;
            up_adv = 1'b0;
          end else begin
            v_adv = sum[WIDTH-1:0];
          end
        end else if (v_q < step_q) begin
          v_adv  = '0;
          up_adv = 1'b1;
        end else begin
          v_adv = v_q - step_q;
        end
      end
      ModeSquare: begin
        if (h_q == period_last) begin
          h_adv   = '0;
          lvl_adv = ~lvl_q;
        end else begin
          h_adv = h_q + PERIOD_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    amp_d    = amp_q;
    step_d   = step_q;
    period_d = period_q;
    count_d  = count_q;
    cnt_d    = cnt_q;
    v_d      = v_q;
    up_d     = up_q;
    h_d      = h_q;
    lvl_d    = lvl_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    load     = 1'b0;
    shape    = '0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d  = StRun;
          mode_d   = mode_e'(mode_i);
          amp_d    = amp_i;
          step_d   = step_i;
          period_d = period_i;
          count_d  = count_i;
          cnt_d    = '0;
          v_d      = '0;
          up_d     = 1'b1;
          h_d      = '0;
          lvl_d    = 1'b1;
          valid_d  = 1'b1;
          load     = 1'b1;
          shape    = (mode_i[1] == 1'b0) ? '0 : amp_i;
        end
      end
      StRun: begin
        if (hs) begin
          cnt_d = cnt_q + 16'd1;
          if (stop_i || last_beat) begin
            state_d = StIdle;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            v_d   = v_adv;
            up_d  = up_adv;
            h_d   = h_adv;
            lvl_d = lvl_adv;
            load  = 1'b1;
            case (mode_q)
              ModeSaw, ModeTri: shape = v_adv;
              ModeSquare:       shape = lvl_adv ? amp_q : '0;
              default:          shape = amp_q;
            endcase
          end
        end else if (stop_i) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (hs) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = StIdle;
          valid_d = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef LAB_11_GEN_NOISE_EN
  logic [15:0]    lfsr_q, lfsr_d;
  logic [WIDTH:0] noisy;

  // Galois form of x^16+x^14+x^13+x^11+1; the noise on a new sample uses the
  // value after this beat's advance.
  assign lfsr_d = hs ? ({1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000)) : lfsr_q;
  assign noisy  = {1'b0, shape} + {{(WIDTH + 1 - NOISE_BITS){1'b0}}, lfsr_d[NOISE_BITS-1:0]};

  always_comb begin
    data_d = data_q;
    if (load) data_d = noisy[WIDTH] ? '1 : noisy[WIDTH-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end
`else
  always_comb begin
    data_d = data_q;
    if (load) data_d = shape;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q  <= StIdle;
      mode_q   <= ModeSaw;
      amp_q    <= '0;
      step_q   <= '0;
      period_q <= '0;
      count_q  <= '0;
      cnt_q    <= '0;
      v_q      <= '0;
      up_q     <= 1'b1;
      h_q      <= '0;
      lvl_q    <= 1'b1;
      data_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      amp_q    <= amp_d;
      step_q   <= step_d;
      period_q <= period_d;
      count_q  <= count_d;
      cnt_q    <= cnt_d;
      v_q      <= v_d;
      up_q     <= up_d;
      h_q      <= h_d;
      lvl_q    <= lvl_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  assign src.data  = data_q;
  assign src.valid = valid_q;
  assign busy_o    = (state_q != StIdle);
  assign done_o    = done_q;

endmodule

// File: tb/tb_lab_11_gen.sv
// Self-checking bench for lab_11_gen (noise feature disabled).
module tb_lab_11_gen;
  localparam int unsigned W = 16;

  logic        clk = 1'b0;
  logic        srst, start, stop;
  logic [1:0]  mode;
  logic [W-1:0] amp, step;
  logic [7:0]  period;
  logic [15:0] count;
  logic        busy, done;

  lab_11_gen_if #(.WIDTH(W)) src_if ();

  lab_11_gen #(.WIDTH(W), .PERIOD_W(8), .NOISE_BITS(3)) dut (
    .clk_i   (clk),
    .srst_i  (srst),
    .start_i (start),
    .stop_i  (stop),
    .mode_i  (mode),
    .amp_i   (amp),
    .step_i  (step),
    .period_i(period),
    .count_i (count),
    .src     (src_if),
    .busy_o  (busy),
    .done_o  (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  longint exp_q[$];
  longint got_q[$];
  int hold_err, gap_cnt;
  bit done_ok, timeout;

  always @(negedge clk) if (done) done_cnt++;

  // Reference: expected sample list straight from the waveform rules.
  task automatic gen_expected(input int md, input longint a, input longint s, input int per,
                              input int n);
    longint v = 0;
    bit up = 1'b1;
    int p = (per == 0) ? 1 : per;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      case (md)
        0: begin
          exp_q.push_back(v);
          v = (v + s > a) ? 0 : v + s;
        end
        1: begin
          exp_q.push_back(v);
          if (up) begin
            if (v + s >= a) begin v = a; up = 1'b0; end
            else v = v + s;
          end else if (v < s) begin v = 0; up = 1'b1; end
          else v = v - s;
        end
        2: exp_q.push_back(((i / p) % 2 == 0) ? a : 0);
        default: exp_q.push_back(a);
      endcase
    end
  endtask

  // Starts one counted sequence and collects accepted beats under random ready.
  task automatic run_seq(input int md, input int a, input int s, input int per, input int n,
                         input int pct);
    int cyc = 0;
    bit fin = 0, last_pending = 0, stalled = 0;
    logic [W-1:0] held = '0;
    got_q.delete();
    hold_err = 0; gap_cnt = 0; done_ok = 0; timeout = 0;
    @(posedge clk); #1;
    start = 1; mode = 2'(md); amp = 16'(a); step = 16'(s); period = 8'(per); count = 16'(n);
    @(posedge clk); #1;
    start = 0;
    while (!fin && cyc < 3000) begin
      src_if.ready = (int'($urandom_range(99)) < pct);
      @(negedge clk);
      if (last_pending) begin
        done_ok = done && !busy && !src_if.valid;
        fin = 1;
      end else begin
        if (stalled && (!src_if.valid || src_if.data !== held)) hold_err++;
        if (!src_if.valid) gap_cnt++;
        if (src_if.valid && src_if.ready) begin
          got_q.push_back(longint'(src_if.data));
          stalled = 0;
          if (got_q.size() == n) last_pending = 1;
        end else begin
          stalled = src_if.valid;
          held = src_if.data;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    src_if.ready = 0;
    if (!fin) timeout = 1;
  endtask

  task automatic test_reset();
    srst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (src_if.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", src_if.valid); end
    checks++; if (src_if.data !== 16'd0) begin errors++; $display("FAIL reset_data: got %0d want 0", src_if.data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    @(posedge clk); #1;
    srst = 0;
  endtask

  task automatic test_saw();
    int d0;
    // Directed case, then one that exercises the no-wrap ceiling compare.
    for (int k = 0; k < 2; k++) begin
      d0 = done_cnt;
      if (k == 0) begin run_seq(0, 10, 4, 0, 6, 100); gen_expected(0, 10, 4, 0, 6); end
      else begin run_seq(0, 'hFFF0, 'h9000, 0, 4, 100); gen_expected(0, 'hFFF0, 'h9000, 0, 4); end
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL saw_len: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL saw[%0d]: got %0d want %0d", i, got_q[i], exp_q[i]); end
      end
      checks++; if (gap_cnt != 0) begin errors++; $display("FAIL saw_gaps: got %0d want 0", gap_cnt); end
      checks++; if (!done_ok || timeout) begin errors++; $display("FAIL saw_done: got %b want 1", done_ok); end
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL saw_done_pulses: got %0d want 1", done_cnt - d0); end
    end
  endtask

  task automatic test_triangle();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin run_seq(1, 8, 3, 0, 8, 100); gen_expected(1, 8, 3, 0, 8); end
      else begin run_seq(1, 'hFFF0, 'h9000, 0, 7, 100); gen_expected(1, 'hFFF0, 'h9000, 0, 7); end
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL tri_len: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL tri[%0d]: got %0d want %0d", i, got_q[i], exp_q[i]); end
      end
      checks++; if (!done_ok || timeout) begin errors++; $display("FAIL tri_done: got %b want 1", done_ok); end
    end
  endtask

  task automatic test_square();
    int per;
    for (int k = 0; k < 2; k++) begin
      per = (k == 0) ? 2 : 0;
      run_seq(2, 5, 0, per, 6, 100);
      gen_expected(2, 5, 0, per, 6);
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL sq_len: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL sq_p%0d[%0d]: got %0d want %0d", per, i, got_q[i], exp_q[i]); end
      end
      checks++; if (!done_ok || timeout) begin errors++; $display("FAIL sq_done: got %b want 1", done_ok); end
    end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 4; k++) begin
      run_seq(0, 100, 1, 0, 12, 30);
      gen_expected(0, 100, 1, 0, 12);
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_len: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp[%0d]: got %0d want %0d", i, got_q[i], exp_q[i]); end
      end
      checks++; if (hold_err != 0) begin errors++; $display("FAIL bp_hold: got %0d violations want 0", hold_err); end
      checks++; if (!done_ok || timeout) begin errors++; $display("FAIL bp_done: got %b want 1", done_ok); end
    end
  endtask

  task automatic test_random();
    int md, a, s, per, n, pct;
    for (int k = 0; k < 25; k++) begin
      md = int'($urandom_range(3)); a = int'($urandom_range(60)); s = int'($urandom_range(15));
      per = int'($urandom_range(5)); n = int'($urandom_range(24, 1)); pct = int'($urandom_range(100, 20));
      run_seq(md, a, s, per, n, pct);
      gen_expected(md, a, s, per, n);
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_len: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rnd m%0d a%0d s%0d p%0d [%0d]: got %0d want %0d", md, a, s, per, i, got_q[i], exp_q[i]);
        end
      end
      checks++; if (hold_err != 0) begin errors++; $display("FAIL rnd_hold: got %0d want 0", hold_err); end
      checks++; if (!done_ok || timeout) begin errors++; $display("FAIL rnd_done: got %b want 1", done_ok); end
    end
  endtask

  task automatic test_stop();
    int d0 = done_cnt;
    @(posedge clk); #1;
    start = 1; mode = 2'd3; amp = 16'd7; step = 16'd0; period = 8'd0; count = 16'd0;
    @(posedge clk); #1;
    start = 0; src_if.ready = 1;
    repeat (3) begin
      @(negedge clk);
      checks++; if (!(src_if.valid === 1'b1 && src_if.data === 16'd7)) begin errors++; $display("FAIL stop_run: got v=%b d=%0d want v=1 d=7", src_if.valid, src_if.data); end
      @(posedge clk); #1;
    end
    src_if.ready = 0; stop = 1;
    @(posedge clk); #1;
    stop = 0; start = 1; mode = 2'd0; amp = 16'd100;
    @(negedge clk);
    checks++; if (!(busy === 1'b1 && src_if.valid === 1'b1 && src_if.data === 16'd7)) begin errors++; $display("FAIL stop_drain: got b=%b v=%b d=%0d want 1 1 7", busy, src_if.valid, src_if.data); end
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    checks++; if (!(busy === 1'b1 && src_if.valid === 1'b1 && src_if.data === 16'd7)) begin errors++; $display("FAIL stop_start_ignored: got b=%b v=%b d=%0d want 1 1 7", busy, src_if.valid, src_if.data); end
    @(posedge clk); #1;
    src_if.ready = 1;
    @(negedge clk);
    checks++; if (!(src_if.valid === 1'b1 && src_if.data === 16'd7)) begin errors++; $display("FAIL stop_last_beat: got v=%b d=%0d want 1 7", src_if.valid, src_if.data); end
    @(posedge clk); #1;
    src_if.ready = 0;
    @(negedge clk);
    checks++; if (!(done === 1'b1 && busy === 1'b0 && src_if.valid === 1'b0)) begin errors++; $display("FAIL stop_done: got dn=%b b=%b v=%b want 1 0 0", done, busy, src_if.valid); end
    @(posedge clk); #1;
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL stop_pulses: got %0d want 1", done_cnt - d0); end
    // Stop coinciding with a handshake ends the sequence immediately.
    start = 1; mode = 2'd3; amp = 16'd9; count = 16'd0;
    @(posedge clk); #1;
    start = 0; src_if.ready = 1; stop = 1;
    @(negedge clk);
    checks++; if (!(src_if.valid === 1'b1 && src_if.data === 16'd9)) begin errors++; $display("FAIL stophs_beat: got v=%b d=%0d want 1 9", src_if.valid, src_if.data); end
    @(posedge clk); #1;
    stop = 0; src_if.ready = 0;
    @(negedge clk);
    checks++; if (!(done === 1'b1 && busy === 1'b0)) begin errors++; $display("FAIL stophs_done: got dn=%b b=%b want 1 0", done, busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_srst();
    int d0 = done_cnt;
    start = 1; mode = 2'd0; amp = 16'd100; step = 16'd1; count = 16'd0;
    @(posedge clk); #1;
    start = 0; src_if.ready = 1;
    repeat (4) @(posedge clk);
    #1;
    srst = 1; start = 1; stop = 1;
    @(posedge clk); #1;
    srst = 0; start = 0; stop = 0;
    @(negedge clk);
    checks++; if (!(src_if.valid === 1'b0 && busy === 1'b0 && src_if.data === 16'd0 && done === 1'b0))
      begin errors++; $display("FAIL srst_mid: got v=%b b=%b d=%0d dn=%b want 0 0 0 0", src_if.valid, busy, src_if.data, done); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (done_cnt != d0 || busy !== 1'b0) begin errors++; $display("FAIL srst_no_done: got pulses=%0d busy=%b want 0 0", done_cnt - d0, busy); end
    src_if.ready = 0;
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    start = 1; mode = 2'd0; amp = 16'd10; step = 16'd4; period = 8'd0; count = 16'd2;
    @(posedge clk); #1;
    start = 0; src_if.ready = 1;
    @(negedge clk);
    checks++; if (src_if.data !== 16'd0) begin errors++; $display("FAIL b2b_a0: got %0d want 0", src_if.data); end
    @(negedge clk);
    checks++; if (src_if.data !== 16'd4) begin errors++; $display("FAIL b2b_a1: got %0d want 4", src_if.data); end
    @(negedge clk);
    checks++; if (!(done === 1'b1 && busy === 1'b0)) begin errors++; $display("FAIL b2b_done1: got dn=%b b=%b want 1 0", done, busy); end
    start = 1; mode = 2'd2; amp = 16'd5; period = 8'd1; count = 16'd2;
    @(negedge clk);
    start = 0;
    checks++; if (!(busy === 1'b1 && src_if.valid === 1'b1 && src_if.data === 16'd5)) begin errors++; $display("FAIL b2b_b0: got b=%b v=%b d=%0d want 1 1 5", busy, src_if.valid, src_if.data); end
    @(negedge clk);
    checks++; if (src_if.data !== 16'd0) begin errors++; $display("FAIL b2b_b1: got %0d want 0", src_if.data); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done2: got %b want 1", done); end
    @(posedge clk); #1;
    src_if.ready = 0;
  endtask

  initial begin
    srst = 1; start = 0; stop = 0; mode = 0; amp = 0; step = 0; period = 0; count = 0;
    src_if.ready = 0;
    test_reset();
    test_saw();
    test_triangle();
    test_square();
    test_backpressure();
    test_random();
    test_stop();
    test_srst();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lab_11_gen.md
# lab_11_gen

Streaming test-waveform source that drives the sink side of the lab_11 moving-average filter. On `start_i` it latches a waveform configuration and emits a counted (or unbounded) sequence of sawtooth, triangle, square or constant samples over a valid/ready handshake, one sample per accepted beat. It is the transmitting end of the filter's data path in the lab_11 bench and system.

## Interface
- `WIDTH`, 16: sample width; must equal the filter's `WIDTH`.
- `PERIOD_W`, 8: width of `period_i`.
- `NOISE_BITS`, 3: width of the additive LFSR noise (used only when `LAB_11_GEN_NOISE_EN` is defined); 1..WIDTH.

Ports:
- `clk_i`  in  1  clock. One clock domain; all logic is on the rising edge.
- `srst_i`  in  1  reset. Synchronous, active-high.
- `start_i`  in  1  start request. Sampled only in IDLE.
- `stop_i`  in  1  abort request. Sampled in RUN.
- `mode_i`  in  2  waveform: 0 saw, 1 triangle, 2 square, 3 constant. Latched at start.
- `amp_i`  in  WIDTH  amplitude or ceiling (unsigned). Latched at start.
- `step_i`  in  WIDTH  saw/triangle increment. Latched at start.
- `period_i`  in  PERIOD_W  square half-period in samples; 0 is treated as 1. Latched at start.
- `count_i`  in  16  samples to emit; 0 means unbounded. Latched at start.
- `src_data_o`  out  WIDTH  sample.
- `src_valid_o`  out  1  sample valid.
- `src_ready_i`  in  1  sink ready.
- `busy_o`  out  1  high in RUN and DRAIN.
- `done_o`  out  1  one-cycle pulse on sequence end.

## Operation
- FSM states:
  - IDLE -> RUN on `start_i`.
  - RUN -> IDLE on the final handshake (`count_i` reached).
  - RUN -> IDLE on `stop_i` together with a handshake in the same cycle.
  - RUN -> DRAIN on `stop_i` without a handshake.
  - DRAIN -> IDLE on a handshake.
- Handshake: a beat transfers when `src_valid_o && src_ready_i`. Once asserted, `src_valid_o` stays high and `src_data_o` stays stable until the transfer. Valid never drops without a handshake, so a stop or the count limit never truncates a presented beat. Valid is high in RUN and DRAIN, low in IDLE.
- Waveform state (value `v`, direction `up`, half-period counter `h`, level `lvl`) advances only on a handshake. Next-value arithmetic is done at WIDTH+1 bits, with no wrap.
  - Saw: `v` starts at 0. Next value is `v+step`; if that exceeds `amp`, the next value is 0.
  - Triangle: `v` starts at 0 with `up=1`.
    - While up: if `v+step >= amp`, then `v=amp` and `up=0`; otherwise `v+=step`.
    - While down: if `v < step`, then `v=0` and `up=1`; otherwise `v-=step`.
  - Square: `lvl` starts at 1 and the output is `lvl ? amp : 0`. `h` counts from 0 to period-1; on `h==period-1`, `h=0` and `lvl` toggles.
  - Constant: the output is always `amp`.
- `step=0` gives a constant 0 for saw and triangle (legal). `amp=0` gives all zeros.
- Emitted-sample counter increments per handshake. With `count_i != 0`, the handshake where the counter reaches `count_i` is the last one.
- `done_o` pulses on the cycle after the last handshake, for both normal completion and stop. That same cycle is the first cycle `busy_o` reads 0.
- `start_i` while busy is ignored. `stop_i` in IDLE is ignored.

## Timing
- Reset values: `src_valid_o`=0, `src_data_o`=0, `busy_o`=0, `done_o`=0; state is IDLE; counters are 0.
- `start_i` high at edge t: `src_valid_o` and `busy_o` are high after edge t, carrying the first sample (0 for saw/triangle, `amp` for square/constant).
- Throughput: one sample per cycle while `src_ready_i` stays high. A new sample appears the cycle after each handshake.
- `src_data_o` is registered; no combinational path from `src_ready_i` to outputs.
- Minimum IDLE gap: `start_i` is accepted on the first cycle `busy_o`=0, so back-to-back sequences are possible.
- `srst_i` mid-sequence: all outputs return to reset values at the next edge, with no `done_o`. It overrides `start_i` and `stop_i` in the same cycle.

## Configuration
- `LAB_11_GEN_NOISE_EN` defined:
  - A 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1, reset seed 16'hACE1) advances once per handshake.
  - `src_data_o` = waveform + `lfsr[NOISE_BITS-1:0]`, saturated at 2^WIDTH-1.
  - The LFSR is not reset by `start_i`.
- Not defined: no LFSR, `src_data_o` is the exact waveform, and `NOISE_BITS` is ignored.

## Test plan
All scenarios use `WIDTH`=16 and the noise macro undefined unless stated.
- Saw, `amp=10`, `step=4`, `count=6`, ready held high -> 0,4,8,0,4,8 on consecutive cycles; `done_o` pulses one cycle after the 6th beat.
- Triangle, `amp=8`, `step=3`, `count=8` -> 0,3,6,8,5,2,0,3.
- Square, `period=2`, `amp=5`, `count=6` -> 5,5,0,0,5,5; repeat with `period=0` -> 5,0,5,0,5,0.
- Backpressure: saw `amp=100`, `step=1`, ready pattern 1,0,0,1,0,1 -> data and valid are held through the low cycles; accepted sequence 0,1,2 with no skips or duplicates.
- Stop: unbounded constant `amp=7`; `stop_i` with ready=0 -> DRAIN with valid held; ready=1 -> one more beat of 7, then `done_o`; `start_i` while busy is ignored.
- `srst_i` mid-run -> valid, busy and data are 0 on the next cycle with no `done_o`. With the macro defined, the first noise added after reset is 16'hACE1[2:0]=1.
